// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: register indices, register count, the retire
// status encoding and the register-file state machine encoding.
package y86_pkg;

    localparam logic [3:0] RNONE = 4'hF;  // "no register" selector
    localparam logic [3:0] RRSP  = 4'h4;  // %rsp
    localparam int         NREG  = 15;    // architectural registers 0..14

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_e;

    typedef enum logic {
        RF_RUN  = 1'b0,
        RF_STOP = 1'b1
    } rf_state_e;

endpackage

// File: rtl/stat_encode.sv
// Retire status priority encoder.
// Ports:
//   imem_error_i  - address error on the retiring instruction (highest priority)
//   instr_valid_i - retiring instruction decoded as legal
//   hlt_i         - retiring instruction is halt
//   stat_o        - ADR > INS > HLT > AOK
module stat_encode
    import y86_pkg::*;
(
    input  logic  imem_error_i,
    input  logic  instr_valid_i,
    input  logic  hlt_i,
    output stat_e stat_o
);

    // Address errors mask everything, then illegal opcodes, then halt.
    always_comb begin
        stat_o = STAT_AOK;
        if (imem_error_i) begin
            stat_o = STAT_ADR;
        end else if (!instr_valid_i) begin
            stat_o = STAT_INS;
        end else if (hlt_i) begin
            stat_o = STAT_HLT;
        end else begin
            stat_o = STAT_AOK;
        end
    end

endmodule

// File: rtl/regfile.sv
// Y86-64 architectural register file with retire-status tracking.
// Accepts writeback of valE/valM to dstE/dstM, serves two combinational read
// ports, and latches the processor status when a retiring instruction halts
// or faults; after that, architectural state is frozen until rst_i.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle read forwarding).
// Ports:
//   clk_i, rst_i                 - clock, synchronous active-high reset
//   wb_valid_i, icode_i          - retiring instruction present / its icode (trace only)
//   dstE_i/valE_i, dstM_i/valM_i - writeback destinations and data (4'hF = none)
//   instr_valid_i, hlt_i, imem_error_i - retire status inputs
//   srcA_i/valA_o, srcB_i/valB_o - read ports (4'hF reads as 0)
//   stat_o, halted_o             - latched status, high in STOP
//   retired_cnt_o                - instructions retired while running
module regfile
    import y86_pkg::*;
#(
    parameter logic [63:0] RSP_INIT = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_valid_i,
    input  logic [3:0]  icode_i,
    input  logic [3:0]  dstE_i,
    input  logic [63:0] valE_i,
    input  logic [3:0]  dstM_i,
    input  logic [63:0] valM_i,
    input  logic        instr_valid_i,
    input  logic        hlt_i,
    input  logic        imem_error_i,
    input  logic [3:0]  srcA_i,
    input  logic [3:0]  srcB_i,
    output logic [63:0] valA_o,
    output logic [63:0] valB_o,
    output logic [1:0]  stat_o,
    output logic        halted_o,
    output logic [63:0] retired_cnt_o
);

    logic [63:0] regs_r [NREG];
    rf_state_e   state_r;
    rf_state_e   next_state_s;
    stat_e       stat_r;
    stat_e       retire_stat_s;
    logic        halted_r;
    logic [63:0] cnt_r;
    logic        accept_s;
    logic        wr_en_s;
    logic [63:0] stored_a_s;
    logic [63:0] stored_b_s;
    logic        icode_unused_s;

    // icode is carried for tracing only.
    assign icode_unused_s = ^icode_i;

    stat_encode u_stat_encode (
        .imem_error_i  (imem_error_i),
        .instr_valid_i (instr_valid_i),
        .hlt_i         (hlt_i),
        .stat_o        (retire_stat_s)
    );

    // A retire is consumed only while running; only AOK retires write.
    assign accept_s = wb_valid_i && (state_r == RF_RUN);
    assign wr_en_s  = accept_s && (retire_stat_s == STAT_AOK);

    // Next-state logic: any non-AOK retire in RUN stops the machine for good.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            RF_RUN: begin
                if (accept_s && (retire_stat_s != STAT_AOK)) begin
                    next_state_s = RF_STOP;
                end else begin
                    next_state_s = RF_RUN;
                end
            end
            RF_STOP: next_state_s = RF_STOP;
            default: next_state_s = RF_RUN;
        endcase
    end

    // State, status, halted flag and retire counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= RF_RUN;
            stat_r   <= STAT_AOK;
            halted_r <= 1'b0;
            cnt_r    <= 64'h0;
        end else begin
            state_r  <= next_state_s;
            halted_r <= (next_state_s == RF_STOP);
            if (accept_s && (retire_stat_s != STAT_AOK)) begin
                stat_r <= retire_stat_s;
            end else begin
                stat_r <= stat_r;
            end
            if (accept_s) begin
                cnt_r <= cnt_r + 64'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Register storage; valM has priority over valE on a shared destination.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst_i) begin
                regs_r[i] <= (4'(i) == RRSP) ? RSP_INIT : 64'h0;
            end else if (wr_en_s && (dstM_i == 4'(i))) begin
                regs_r[i] <= valM_i;
            end else if (wr_en_s && (dstE_i == 4'(i))) begin
                regs_r[i] <= valE_i;
            end else begin
                regs_r[i] <= regs_r[i];
            end
        end
    end

    // Stored-value lookup; RNONE is not backed by storage.
    always_comb begin
        stored_a_s = 64'h0;
        stored_b_s = 64'h0;
        if (srcA_i != RNONE) begin
            stored_a_s = regs_r[srcA_i];
        end else begin
            stored_a_s = 64'h0;
        end
        if (srcB_i != RNONE) begin
            stored_b_s = regs_r[srcB_i];
        end else begin
            stored_b_s = 64'h0;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the value that will be written at the coming edge, valM first.
    function automatic logic [63:0] forward(input logic [3:0]  src,
                                            input logic [63:0] stored);
        logic [63:0] res;
        if (wr_en_s && (src != RNONE) && (src == dstM_i)) begin
            res = valM_i;
        end else if (wr_en_s && (src != RNONE) && (src == dstE_i)) begin
            res = valE_i;
        end else begin
            res = stored;
        end
        return res;
    endfunction

    // Read ports with same-cycle forwarding.
    always_comb begin
        valA_o = forward(srcA_i, stored_a_s);
        valB_o = forward(srcB_i, stored_b_s);
    end
`else
    // Read ports return stored contents only.
    always_comb begin
        valA_o = stored_a_s;
        valB_o = stored_b_s;
    end
`endif

    assign stat_o        = stat_r;
    assign halted_o      = halted_r;
    assign retired_cnt_o = cnt_r;

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

    localparam logic [63:0] RSP = 64'h200;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [3:0]  icode;
    logic [3:0]  dst_e;
    logic [63:0] val_e;
    logic [3:0]  dst_m;
    logic [63:0] val_m;
    logic        instr_valid;
    logic        hlt;
    logic        imem_error;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [1:0]  stat;
    logic        halted;
    logic [63:0] cnt;

    int checks = 0;
    int errors = 0;

    regfile #(.RSP_INIT(RSP)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .wb_valid_i    (wb_valid),
        .icode_i       (icode),
        .dstE_i        (dst_e),
        .valE_i        (val_e),
        .dstM_i        (dst_m),
        .valM_i        (val_m),
        .instr_valid_i (instr_valid),
        .hlt_i         (hlt),
        .imem_error_i  (imem_error),
        .srcA_i        (src_a),
        .srcB_i        (src_b),
        .valA_o        (val_a),
        .valB_o        (val_b),
        .stat_o        (stat),
        .halted_o      (halted),
        .retired_cnt_o (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wbv;
        logic [3:0]  de;
        logic [63:0] ve;
        logic [3:0]  dm;
        logic [63:0] vm;
        logic        iv;
        logic        h;
        logic        ie;
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
        logic [1:0]  exp_stat;
        logic        exp_halt;
        logic [63:0] exp_cnt;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_wb();
        wb_valid    = 1'b0;
        dst_e       = 4'hF;
        val_e       = 64'h0;
        dst_m       = 4'hF;
        val_m       = 64'h0;
        instr_valid = 1'b1;
        hlt         = 1'b0;
        imem_error  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        // A writeback during reset must be discarded.
        wb_valid = 1'b1;
        dst_e    = 4'h0;
        val_e    = 64'hFF;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_wb();
    endtask

    task automatic retire(input logic [3:0] de, input logic [63:0] ve,
                          input logic [3:0] dm, input logic [63:0] vm,
                          input logic iv, input logic h, input logic ie);
        wb_valid    = 1'b1;
        dst_e       = de;
        val_e       = ve;
        dst_m       = dm;
        val_m       = vm;
        instr_valid = iv;
        hlt         = h;
        imem_error  = ie;
        @(posedge clk);
        #1;
        idle_wb();
    endtask

    initial begin
        rst   = 1'b1;
        icode = 4'h0;
        src_a = 4'h0;
        src_b = 4'h0;
        idle_wb();

        //          wbv   de     ve          dm     vm         iv    h     ie    sa     sb     exp_a       exp_b       st     hl    cnt
        vecs[0] = '{1'b1, 4'h2, 64'hDEAD,   4'hF, 64'h0,    1'b1, 1'b0, 1'b0, 4'h2, 4'h4, 64'hDEAD,   RSP,        2'd0, 1'b0, 64'd1};
        vecs[1] = '{1'b1, 4'h4, 64'h100,    4'h4, 64'h55,   1'b1, 1'b0, 1'b0, 4'h4, 4'h2, 64'h55,     64'hDEAD,   2'd0, 1'b0, 64'd2};
        vecs[2] = '{1'b1, 4'h0, 64'h1111,   4'hE, 64'h2222, 1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 64'h1111,   64'h2222,   2'd0, 1'b0, 64'd3};
        vecs[3] = '{1'b0, 4'h0, 64'h9999,   4'h1, 64'h7777, 1'b0, 1'b1, 1'b1, 4'h0, 4'hF, 64'h1111,   64'h0,      2'd0, 1'b0, 64'd3};
        vecs[4] = '{1'b1, 4'hF, 64'h5,      4'h1, 64'hABC,  1'b1, 1'b0, 1'b0, 4'h1, 4'h1, 64'hABC,    64'hABC,    2'd0, 1'b0, 64'd4};
        vecs[5] = '{1'b1, 4'hF, 64'h6,      4'hF, 64'h6,    1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 64'h0,      64'h1111,   2'd0, 1'b0, 64'd5};
        vecs[6] = '{1'b1, 4'h3, 64'h7,      4'hF, 64'h0,    1'b1, 1'b1, 1'b0, 4'h3, 4'h3, 64'h0,      64'h0,      2'd1, 1'b1, 64'd6};
        vecs[7] = '{1'b1, 4'h3, 64'h8,      4'hF, 64'h0,    1'b1, 1'b0, 1'b0, 4'h3, 4'h4, 64'h0,      64'h55,     2'd1, 1'b1, 64'd6};
        vecs[8] = '{1'b1, 4'h4, 64'h1,      4'h4, 64'h2,    1'b0, 1'b0, 1'b1, 4'h4, 4'h0, 64'h55,     64'h1111,   2'd1, 1'b1, 64'd6};

        do_reset();
        src_a = 4'h4;
        src_b = 4'h0;
        #1;
        chk("reset_rsp", val_a, RSP);
        chk("reset_r0", val_b, 64'h0);
        chk("reset_stat", {62'h0, stat}, 64'd0);
        chk("reset_halted", {63'h0, halted}, 64'd0);
        chk("reset_cnt", cnt, 64'd0);

        for (int i = 0; i < 9; i++) begin
            wb_valid    = vecs[i].wbv;
            dst_e       = vecs[i].de;
            val_e       = vecs[i].ve;
            dst_m       = vecs[i].dm;
            val_m       = vecs[i].vm;
            instr_valid = vecs[i].iv;
            hlt         = vecs[i].h;
            imem_error  = vecs[i].ie;
            @(posedge clk);
            #1;
            idle_wb();
            src_a = vecs[i].sa;
            src_b = vecs[i].sb;
            #1;
            chk($sformatf("vec%0d_valA", i), val_a, vecs[i].exp_a);
            chk($sformatf("vec%0d_valB", i), val_b, vecs[i].exp_b);
            chk($sformatf("vec%0d_stat", i), {62'h0, stat}, {62'h0, vecs[i].exp_stat});
            chk($sformatf("vec%0d_halted", i), {63'h0, halted}, {63'h0, vecs[i].exp_halt});
            chk($sformatf("vec%0d_cnt", i), cnt, vecs[i].exp_cnt);
        end

        // Address error together with illegal instruction: ADR wins, no write.
        do_reset();
        src_a = 4'h3;
        src_b = 4'h6;
        #1;
        chk("rst2_r3", val_a, 64'h0);
        wb_valid    = 1'b1;
        dst_m       = 4'h6;
        val_m       = 64'h1;
        instr_valid = 1'b0;
        imem_error  = 1'b1;
        #1;
        chk("fault_edge_stat", {62'h0, stat}, 64'd0);
        chk("fault_edge_halted", {63'h0, halted}, 64'd0);
        @(posedge clk);
        #1;
        idle_wb();
        #1;
        chk("adr_stat", {62'h0, stat}, 64'd2);
        chk("adr_halted", {63'h0, halted}, 64'd1);
        chk("adr_nowrite", val_b, 64'h0);
        chk("adr_cnt", cnt, 64'd1);
        do_reset();
        #1;
        chk("rst3_stat", {62'h0, stat}, 64'd0);
        chk("rst3_halted", {63'h0, halted}, 64'd0);

        // Illegal instruction alone.
        retire(4'h6, 64'h3, 4'hF, 64'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("ins_stat", {62'h0, stat}, 64'd3);
        chk("ins_nowrite", val_b, 64'h0);

        // Same-cycle read of a register being written.
        do_reset();
        src_a = 4'h7;
        src_b = 4'h5;
        wb_valid = 1'b1;
        dst_e    = 4'h7;
        val_e    = 64'hA;
        dst_m    = 4'h5;
        val_m    = 64'h9;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle_valB", val_b, 64'h9);
        chk("same_cycle_valA", val_a, 64'hA);
`else
        chk("same_cycle_valB", val_b, 64'h0);
        chk("same_cycle_valA", val_a, 64'h0);
`endif
        @(posedge clk);
        #1;
        idle_wb();
        #1;
        chk("next_cycle_valB", val_b, 64'h9);
        chk("next_cycle_valA", val_a, 64'hA);
        chk("final_cnt", cnt, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
